// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one I2C master.
// A winner owns the master from grant until a one-cycle done pulse. The
// transaction ends on the master's completion or on a cycle-count timeout.
module i2c_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    input  logic [NREQ-1:0]   req_rw,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              nack_err,
    output logic              to_err,
    output logic              m_en,
    output logic [6:0]        m_address,
    output logic [7:0]        m_data_in,
    output logic              m_read_write,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic              m_nack,
    input  logic [7:0]        m_data_out
);

    // NREQ is a power of two, so pointer arithmetic wraps modulo NREQ.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, ptr_nx;
    logic [PW-1:0]   winner, winner_nx;
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [15:0]     cnt, cnt_nx;
    logic            tc;

    logic [NREQ-1:0] gnt_nx, done_nx;
    logic [7:0]      rdata_nx;
    logic            nack_err_nx, to_err_nx, m_en_nx;
    logic [6:0]      m_address_nx;
    logic [7:0]      m_data_in_nx;
    logic            m_read_write_nx;

    // The timeout fires on the cycle the counter reaches its terminal value.
    assign tc = (cnt == 16'(TIMEOUT - 1));

    // Round-robin search from ptr. Offsets are scanned high to low, so the
    // lowest offset with a pending request is assigned last and wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[ptr + PW'(i)]) begin
                pick     = ptr + PW'(i);
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state and output logic. Every register holds its value by
    // default. done is the only output cleared by default, which makes it
    // a single-cycle pulse.
    always_comb begin
        state_nx        = state;
        ptr_nx          = ptr;
        winner_nx       = winner;
        cnt_nx          = cnt;
        gnt_nx          = gnt;
        done_nx         = '0;
        rdata_nx        = rdata;
        nack_err_nx     = nack_err;
        to_err_nx       = to_err;
        m_en_nx         = m_en;
        m_address_nx    = m_address;
        m_data_in_nx    = m_data_in;
        m_read_write_nx = m_read_write;

        case (state)
            IDLE: begin
                // Latch the winner's fields here. Later req_* changes cannot
                // reach the master until the next grant.
                if (pick_vld) begin
                    winner_nx       = pick;
                    gnt_nx          = NREQ'(1) << pick;
                    m_address_nx    = req_addr[int'(pick)*7 +: 7];
                    m_data_in_nx    = req_wdata[int'(pick)*8 +: 8];
                    m_read_write_nx = req_rw[pick];
                    m_en_nx         = 1'b1;
                    cnt_nx          = '0;
                    state_nx        = ISSUE;
                end
            end

            ISSUE: begin
                // m_done is ignored in this state. Only busy and timeout
                // move the FSM forward.
                cnt_nx = cnt + 16'd1;
                if (tc) begin
                    to_err_nx   = 1'b1;
                    nack_err_nx = 1'b0;
                    rdata_nx    = '0;
                    m_en_nx     = 1'b0;
                    done_nx     = gnt;
                    state_nx    = COMPLETE;
                end else if (m_busy) begin
                    m_en_nx  = 1'b0;
                    state_nx = WAIT;
                end
            end

            WAIT: begin
                // m_done is tested first, so a completion on the terminal
                // count cycle is reported as a normal completion.
                cnt_nx = cnt + 16'd1;
                if (m_done) begin
                    rdata_nx    = m_data_out;
                    nack_err_nx = m_nack;
                    to_err_nx   = 1'b0;
                    done_nx     = gnt;
                    state_nx    = COMPLETE;
                end else if (tc) begin
                    to_err_nx   = 1'b1;
                    nack_err_nx = 1'b0;
                    rdata_nx    = '0;
                    m_en_nx     = 1'b0;
                    done_nx     = gnt;
                    state_nx    = COMPLETE;
                end
            end

            COMPLETE: begin
                // done is high during this state. Release the grant and
                // move the pointer past the winner.
                gnt_nx   = '0;
                ptr_nx   = winner + 1'b1;
                state_nx = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            winner       <= '0;
            cnt          <= '0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            nack_err     <= 1'b0;
            to_err       <= 1'b0;
            m_en         <= 1'b0;
            m_address    <= '0;
            m_data_in    <= '0;
            m_read_write <= 1'b0;
        end else begin
            state        <= state_nx;
            ptr          <= ptr_nx;
            winner       <= winner_nx;
            cnt          <= cnt_nx;
            gnt          <= gnt_nx;
            done         <= done_nx;
            rdata        <= rdata_nx;
            nack_err     <= nack_err_nx;
            to_err       <= to_err_nx;
            m_en         <= m_en_nx;
            m_address    <= m_address_nx;
            m_data_in    <= m_data_in_nx;
            m_read_write <= m_read_write_nx;
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with TIMEOUT=20. The I2C master is modelled
// inline by each scenario task.
module tb_i2c_arbiter;

    logic        clk, rst;
    logic [3:0]  req, req_rw;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, done;
    logic [7:0]  rdata;
    logic        nack_err, to_err, m_en;
    logic [6:0]  m_address;
    logic [7:0]  m_data_in;
    logic        m_read_write;
    logic        m_busy, m_done, m_nack;
    logic [7:0]  m_data_out;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_arbiter #(.NREQ(4), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rw(req_rw), .gnt(gnt), .done(done),
        .rdata(rdata), .nack_err(nack_err), .to_err(to_err), .m_en(m_en),
        .m_address(m_address), .m_data_in(m_data_in),
        .m_read_write(m_read_write), .m_busy(m_busy), .m_done(m_done),
        .m_nack(m_nack), .m_data_out(m_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until a grant appears, with a bounded number of edges.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnt !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Master handshake: busy, a short wait, then a done pulse. Returns with
    // the arbiter in COMPLETE.
    task automatic master_finish(input bit nack, input logic [7:0] dout);
        m_busy = 1'b1;
        step();
        step();
        step();
        m_done = 1'b1; m_nack = nack; m_data_out = dout;
        step();
        m_done = 1'b0; m_nack = 1'b0; m_busy = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        rst = 1'b1;
        step();
        outs = {gnt, done, m_en, m_address, m_data_in, m_read_write, rdata, nack_err, to_err};
        n_cmp++;
        if (outs !== 41'd0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", outs); end
        rst = 1'b0;
        step(); step();
        n_cmp++;
        if (gnt !== 4'b0000 || m_en !== 1'b0) begin
            n_bad++; $display("FAIL idle_no_req: gnt %b m_en %b want 0000 0", gnt, m_en);
        end
    endtask

    task automatic test_write();
        bit ok;
        // An m_done pulse while idle must not complete anything.
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        n_cmp++;
        if (done !== 4'b0000 || gnt !== 4'b0000) begin
            n_bad++; $display("FAIL idle_mdone: done %b gnt %b want 0000 0000", done, gnt);
        end
        req_addr[6:0] = 7'h50; req_wdata[7:0] = 8'hA5; req_rw = 4'b0000; req = 4'b0001;
        wait_grant(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL write_grant_wait: no grant within bound"); end
        n_cmp++;
        if (gnt !== 4'b0001 || m_en !== 1'b1) begin
            n_bad++; $display("FAIL write_grant: gnt %b m_en %b want 0001 1", gnt, m_en);
        end
        n_cmp++;
        if (m_address !== 7'h50 || m_data_in !== 8'hA5 || m_read_write !== 1'b0) begin
            n_bad++; $display("FAIL write_fields: addr %h data %h rw %b want 50 a5 0", m_address, m_data_in, m_read_write);
        end
        // Drop req and change the fields mid-transaction. Both are ignored.
        req = 4'b0000; req_addr[6:0] = 7'h11; req_wdata[7:0] = 8'h22;
        m_busy = 1'b1;
        step();
        n_cmp++;
        if (m_en !== 1'b0 || m_address !== 7'h50 || m_data_in !== 8'hA5) begin
            n_bad++; $display("FAIL write_busy: m_en %b addr %h data %h want 0 50 a5", m_en, m_address, m_data_in);
        end
        step();
        m_done = 1'b1; m_nack = 1'b0; m_data_out = 8'hFF;
        step();
        m_done = 1'b0; m_busy = 1'b0;
        n_cmp++;
        if (done !== 4'b0001 || nack_err !== 1'b0 || to_err !== 1'b0) begin
            n_bad++; $display("FAIL write_done: done %b nack %b to %b want 0001 0 0", done, nack_err, to_err);
        end
        step();
        n_cmp++;
        if (done !== 4'b0000 || gnt !== 4'b0000) begin
            n_bad++; $display("FAIL write_pulse: done %b gnt %b want 0000 0000", done, gnt);
        end
    endtask

    task automatic test_read();
        bit ok;
        req_addr[20:14] = 7'h2A; req_rw = 4'b0100; req = 4'b0100;
        wait_grant(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0100 || m_read_write !== 1'b1 || m_address !== 7'h2A) begin
            n_bad++; $display("FAIL read_grant: gnt %b rw %b addr %h want 0100 1 2a", gnt, m_read_write, m_address);
        end
        // An m_done pulse during ISSUE must be ignored.
        m_done = 1'b1; m_data_out = 8'hEE;
        step();
        m_done = 1'b0;
        n_cmp++;
        if (m_en !== 1'b1 || done !== 4'b0000) begin
            n_bad++; $display("FAIL issue_mdone: m_en %b done %b want 1 0000", m_en, done);
        end
        master_finish(1'b0, 8'h3C);
        n_cmp++;
        if (done !== 4'b0100 || rdata !== 8'h3C) begin
            n_bad++; $display("FAIL read_done: done %b rdata %h want 0100 3c", done, rdata);
        end
        req = 4'b0000;
        step(); step(); step();
        n_cmp++;
        if (rdata !== 8'h3C || done !== 4'b0000) begin
            n_bad++; $display("FAIL read_hold: rdata %h done %b want 3c 0000", rdata, done);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        // ptr is 3 after the read, so requester 3 goes first.
        req_rw = 4'b0000; req = 4'b1001;
        wait_grant(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b1000) begin n_bad++; $display("FAIL to_grant: gnt %b want 1000", gnt); end
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            if (done !== 4'b0000) break;
        end
        n_cmp++;
        if (done !== 4'b1000 || cyc < 19 || cyc > 21) begin
            n_bad++; $display("FAIL to_latency: done %b after %0d cycles want 1000 after 20", done, cyc);
        end
        n_cmp++;
        if (to_err !== 1'b1 || nack_err !== 1'b0 || rdata !== 8'h00 || m_en !== 1'b0) begin
            n_bad++; $display("FAIL to_flags: to %b nack %b rdata %h m_en %b want 1 0 00 0", to_err, nack_err, rdata, m_en);
        end
        wait_grant(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0001) begin n_bad++; $display("FAIL to_next: gnt %b want 0001", gnt); end
        master_finish(1'b0, 8'h5A);
        n_cmp++;
        if (done !== 4'b0001 || to_err !== 1'b0 || rdata !== 8'h5A) begin
            n_bad++; $display("FAIL to_recover: done %b to %b rdata %h want 0001 0 5a", done, to_err, rdata);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_simul();
        bit ok;
        req = 4'b0010;
        wait_grant(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0010) begin n_bad++; $display("FAIL sim_grant: gnt %b want 0010", gnt); end
        // The counter is 0 after the grant edge. m_done is driven so that it
        // is sampled on the terminal-count cycle (count 19).
        m_busy = 1'b1;
        repeat (19) step();
        m_done = 1'b1; m_nack = 1'b1; m_data_out = 8'h77;
        step();
        m_done = 1'b0; m_nack = 1'b0; m_busy = 1'b0;
        n_cmp++;
        if (done !== 4'b0010 || nack_err !== 1'b1 || to_err !== 1'b0 || rdata !== 8'h77) begin
            n_bad++; $display("FAIL sim_done: done %b nack %b to %b rdata %h want 0010 1 0 77", done, nack_err, to_err, rdata);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [40:0] outs;
        // ptr is 2 here. Winner 3 is reset before COMPLETE, so without a
        // reset req=1010 would go to requester 3.
        req = 4'b1000;
        wait_grant(ok);
        m_busy = 1'b1;
        step(); step();
        rst = 1'b1;
        #1;
        outs = {gnt, done, m_en, m_address, m_data_in, m_read_write, rdata, nack_err, to_err};
        n_cmp++;
        if (outs !== 41'd0) begin n_bad++; $display("FAIL rst_mid_outs: got %h want 0", outs); end
        step();
        rst = 1'b0; m_busy = 1'b0; req = 4'b1010;
        wait_grant(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0010) begin n_bad++; $display("FAIL rst_mid_ptr: gnt %b want 0010", gnt); end
        master_finish(1'b0, 8'h01);
        req = 4'b0000;
        step();
    endtask

    task automatic test_fairness();
        bit ok;
        logic [3:0] exp_order [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                      4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_grant(ok);
            n_cmp++;
            if (!ok || gnt !== exp_order[k]) begin
                n_bad++; $display("FAIL fair_%0d: gnt %b want %b", k, gnt, exp_order[k]);
            end
            master_finish(1'b0, 8'h00);
        end
        req = 4'b0000;
        step(); step();
    endtask

    initial begin
        rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_data_out = '0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_simul();
        test_reset_mid();
        test_fairness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
